jpeg_stream_sequencer: RTL and testbench

JPEG_STREAM_SEQUENCER -- requirements
Module: jpeg_stream_sequencer

---
 rtl/jpeg_pkg.sv | 19 +
 rtl/jpeg_stream_sequencer.sv | 162 ++++++++++++++++
 tb/tb_jpeg_stream_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG stream sequencer.
//   jpeg_state_e : frame sequencing states
//   SOI_MARKER   : start-of-image marker word
//   EOI_MARKER   : end-of-image marker word
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOI   = 3'd1,
    ST_HDR   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_EOI   = 3'd5
  } jpeg_state_e;

  localparam logic [15:0] SOI_MARKER = 16'hFFD8;
  localparam logic [15:0] EOI_MARKER = 16'hFFD9;

endpackage

// File: rtl/jpeg_stream_sequencer.sv
// JPEG frame sequencer. It emits the SOI marker, then hdr_len header words
// read from an external ROM, then the byte-stuffed entropy stream coming back
// from an external byte_stuffer, and finally the EOI marker. It also counts
// the words emitted per frame.
//
// Handshake: on every link (scan, stuffer in, stuffer out, downstream), a word
// moves on a clock edge where the sender's ena and the receiver's rdy are both
// high. A sender that has raised ena keeps its data stable until the word moves.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, hdr_len    : begin a frame (accepted only in IDLE), header word count
//   hdr_addr/hdr_data : header ROM address out, combinational ROM word in
//   scan_ena/scan_last/scan_rdy : upstream entropy word handshake
//   st_*              : byte_stuffer control and data links
//   out_data/out_ena/out_rdy    : downstream word stream
//   busy, frame_done, frame_words : status; frame_done pulses once per frame
//   fsm_state         : current sequencing state, for observation
module jpeg_stream_sequencer
  import jpeg_pkg::*;
#(
  parameter int HDR_AW = 9,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HDR_AW:0]   hdr_len,
  output logic [HDR_AW-1:0] hdr_addr,
  input  logic [15:0]       hdr_data,
  input  logic              scan_ena,
  input  logic              scan_last,
  output logic              scan_rdy,
  output logic              st_ena_in,
  input  logic              st_rdy_out,
  output logic              st_rdy_in,
  input  logic              st_ena_out,
  input  logic [15:0]       st_out,
  output logic              st_flush,
  input  logic              st_done,
  output logic              st_rst,
  output logic [15:0]       out_data,
  output logic              out_ena,
  input  logic              out_rdy,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words,
  output jpeg_state_e       fsm_state
);

  localparam logic [HDR_AW:0] HDR_ONE = (HDR_AW+1)'(1);

  jpeg_state_e       state, state_nxt;
  logic [HDR_AW:0]   len_q;
  logic [HDR_AW:0]   hdr_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic              done_q;
  logic              out_xfer;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    hdr_addr  = hdr_cnt[HDR_AW-1:0];
    out_data  = '0;
    out_ena   = 1'b0;
    scan_rdy  = 1'b0;
    st_ena_in = 1'b0;
    st_rdy_in = 1'b0;
    st_flush  = 1'b0;
    st_rst    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SOI;
      end
      ST_SOI: begin
        out_data = SOI_MARKER;
        out_ena  = 1'b1;
        st_rst   = 1'b1;
        if (out_rdy) state_nxt = (len_q == '0) ? ST_SCAN : ST_HDR;
      end
      ST_HDR: begin
        out_data = hdr_data;
        out_ena  = 1'b1;
        if (out_rdy && (hdr_cnt == len_q - HDR_ONE)) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        st_ena_in = scan_ena;
        scan_rdy  = st_rdy_out;
        st_rdy_in = out_rdy;
        out_data  = st_out;
        out_ena   = st_ena_out;
        if (scan_ena && st_rdy_out && scan_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Upstream is closed; only drain what the stuffer still holds.
        st_flush  = 1'b1;
        st_rdy_in = out_rdy;
        out_data  = st_out;
        out_ena   = st_ena_out;
        if (st_done) state_nxt = ST_EOI;
      end
      ST_EOI: begin
        out_data = EOI_MARKER;
        out_ena  = 1'b1;
        if (out_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The state register only clears on the edge, so force the reset-time
    // outputs directly while rst is high.
    if (rst) begin
      state_nxt = ST_IDLE;
      out_ena   = 1'b0;
      scan_rdy  = 1'b0;
      st_ena_in = 1'b0;
      st_rdy_in = 1'b0;
      st_flush  = 1'b0;
      st_rst    = 1'b1;
    end
  end

  assign out_xfer = out_ena && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      hdr_cnt     <= '0;
      word_cnt    <= '0;
      frame_words <= '0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          len_q    <= hdr_len;
          hdr_cnt  <= '0;
          word_cnt <= '0;
        end
      end else begin
        if (out_xfer) word_cnt <= sat_inc(word_cnt);
        if (state == ST_HDR && out_xfer) hdr_cnt <= hdr_cnt + HDR_ONE;
        // The EOI word is included, so take the count it will have after
        // this transfer; frame_done and frame_words appear together.
        if (state == ST_EOI && out_xfer) begin
          done_q      <= 1'b1;
          frame_words <= sat_inc(word_cnt);
        end
      end
    end
  end

  assign busy       = (state != ST_IDLE) && !rst;
  assign frame_done = done_q && !rst;
  assign fsm_state  = state;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Bench for jpeg_stream_sequencer: ROM table, behavioural byte stuffer
// (0x00 inserted after each 0xFF byte, odd tail padded with 0x00 on flush),
// downstream word monitor, and directed frames with hand-built expectations.
module tb_jpeg_stream_sequencer;
  import jpeg_pkg::*;

  localparam int HDR_AW = 9;
  localparam int CNT_W  = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [HDR_AW:0]   hdr_len = '0;
  logic [HDR_AW-1:0] hdr_addr, hdr_addr_s;
  logic [15:0]       hdr_data;
  logic              scan_ena = 1'b0, scan_last = 1'b0;
  logic [15:0]       scan_word = '0;
  logic              scan_rdy, scan_rdy_s;
  logic              st_ena_in, st_rdy_in, st_flush, st_rst;
  logic              st_ena_in_s, st_rdy_in_s, st_flush_s, st_rst_s;
  logic              st_rdy_out, st_ena_out, st_done;
  logic [15:0]       st_out;
  logic [15:0]       out_data, out_data_s;
  logic              out_ena, out_ena_s;
  logic              out_rdy = 1'b1;
  logic              busy, busy_s, frame_done, frame_done_s;
  logic [CNT_W-1:0]  frame_words;
  logic [2:0]        frame_words_s;
  jpeg_state_e       fsm_state, fsm_state_s;

  always #5 clk = ~clk;

  logic [15:0] rom [0:15];
  assign hdr_data = rom[hdr_addr[3:0]];

  jpeg_stream_sequencer #(.HDR_AW(HDR_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .hdr_len(hdr_len),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .scan_ena(scan_ena), .scan_last(scan_last), .scan_rdy(scan_rdy),
    .st_ena_in(st_ena_in), .st_rdy_out(st_rdy_out), .st_rdy_in(st_rdy_in),
    .st_ena_out(st_ena_out), .st_out(st_out), .st_flush(st_flush),
    .st_done(st_done), .st_rst(st_rst),
    .out_data(out_data), .out_ena(out_ena), .out_rdy(out_rdy),
    .busy(busy), .frame_done(frame_done), .frame_words(frame_words),
    .fsm_state(fsm_state)
  );

  // Narrow-counter copy sharing all inputs; it only differs in frame_words.
  jpeg_stream_sequencer #(.HDR_AW(HDR_AW), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .hdr_len(hdr_len),
    .hdr_addr(hdr_addr_s), .hdr_data(hdr_data),
    .scan_ena(scan_ena), .scan_last(scan_last), .scan_rdy(scan_rdy_s),
    .st_ena_in(st_ena_in_s), .st_rdy_out(st_rdy_out), .st_rdy_in(st_rdy_in_s),
    .st_ena_out(st_ena_out), .st_out(st_out), .st_flush(st_flush_s),
    .st_done(st_done), .st_rst(st_rst_s),
    .out_data(out_data_s), .out_ena(out_ena_s), .out_rdy(out_rdy),
    .busy(busy_s), .frame_done(frame_done_s), .frame_words(frame_words_s),
    .fsm_state(fsm_state_s)
  );

  // ---------------- byte stuffer model ----------------
  logic [7:0]  sq[$];
  int unsigned sq_n = 0;
  logic [15:0] sq_word = '0;
  logic        cap_push = 1'b0, cap_pop = 1'b0, cap_clr = 1'b0;
  logic [15:0] cap_word = '0;

  assign st_rdy_out = (sq_n < 8);
  assign st_ena_out = (sq_n >= 2) || (st_flush && sq_n == 1);
  assign st_done    = st_flush && (sq_n == 0);
  assign st_out     = sq_word;

  always @(negedge clk) begin
    cap_push = st_ena_in && st_rdy_out;
    cap_word = scan_word;
    cap_pop  = st_ena_out && st_rdy_in;
    cap_clr  = st_rst;
  end

  always @(posedge clk) begin
    logic [7:0] b;
    #1;
    if (cap_clr) begin
      sq.delete();
    end else begin
      if (cap_pop) begin
        if (sq.size() >= 2) begin
          b = sq.pop_front();
          b = sq.pop_front();
        end else if (sq.size() == 1) begin
          b = sq.pop_front();
        end
      end
      if (cap_push) begin
        b = cap_word[15:8];
        sq.push_back(b);
        if (b == 8'hFF) sq.push_back(8'h00);
        b = cap_word[7:0];
        sq.push_back(b);
        if (b == 8'hFF) sq.push_back(8'h00);
      end
    end
    sq_n    = sq.size();
    sq_word = '0;
    if (sq_n >= 1) sq_word[15:8] = sq[0];
    if (sq_n >= 2) sq_word[7:0]  = sq[1];
  end

  // ---------------- downstream ready pattern ----------------
  logic toggle_mode = 1'b0;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      out_rdy = (ph == 0) || (ph == 3);
      ph = (ph + 1) % 4;
    end else begin
      out_rdy = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          done_cnt = 0, eoi_cnt = 0, stall_bad = 0;
  logic        stall_pend = 1'b0;
  logic [15:0] stall_word = '0;

  always @(negedge clk) begin
    if (!rst && out_ena && out_rdy) begin
      got_q.push_back(out_data);
      if (out_data == EOI_MARKER) eoi_cnt++;
    end
    if (frame_done) done_cnt++;
    if (stall_pend && !rst && !(out_ena && out_data == stall_word)) stall_bad++;
    stall_pend = out_ena && !out_rdy && !rst;
    stall_word = out_data;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] fw_got = '0;
  logic [2:0]       fw_got_s = '0;
  logic [15:0]      scan_vec [0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    eoi_cnt   = 0;
    stall_bad = 0;
  endtask

  task automatic wait_state(input jpeg_state_e s);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (fsm_state == s) seen = 1;
    end
    if (!seen) chk("state_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_scan(input logic [15:0] w, input logic l);
    bit acc = 0;
    scan_ena  = 1'b1;
    scan_word = w;
    scan_last = l;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (scan_rdy) acc = 1;
      tick();
    end
    if (!acc) chk("scan_timeout", 32'd0, 32'd1);
    scan_ena  = 1'b0;
    scan_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen     = 1;
        fw_got   = frame_words;
        fw_got_s = frame_words_s;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic run_frame(input int len, input int n);
    clear_obs();
    hdr_len = (HDR_AW+1)'(len);
    start   = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("started", 32'(busy), 32'd1);
    tick();
    for (int i = 0; i < n; i++) send_scan(scan_vec[i], (i == n - 1));
    wait_done();
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h0;
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_st_rst", 32'(st_rst), 32'd1);
    chk("rst_out_ena", 32'(out_ena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_st_flush", 32'(st_flush), 32'd0);
    chk("rst_scan_rdy", 32'(scan_rdy), 32'd0);
    chk("rst_frame_words", 32'(frame_words), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_out_ena", 32'(out_ena), 32'd0);
    chk("idle_st_rdy_in", 32'(st_rdy_in), 32'd0);
    tick();

    // Basic frame: 3 header words, 2 scan words
    scan_vec[0] = 16'h1234;
    scan_vec[1] = 16'h5678;
    run_frame(3, 2);
    exp_q = '{16'hFFD8, 16'h1111, 16'h2222, 16'h3333, 16'h1234, 16'h5678, 16'hFFD9};
    check_stream("basic");
    chk("basic_fw", 32'(fw_got), 32'd7);
    chk("basic_fw_sat", 32'(fw_got_s), 32'd7);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    // No header, one scan word with an FF byte; starts the cycle after frame_done
    scan_vec[0] = 16'h12FF;
    run_frame(0, 1);
    exp_q = '{16'hFFD8, 16'h12FF, 16'h0000, 16'hFFD9};
    check_stream("nohdr");
    chk("nohdr_fw", 32'(fw_got), 32'd4);
    chk("nohdr_done_cnt", 32'(done_cnt), 32'd1);
    chk("nohdr_busy", 32'(busy), 32'd0);

    // Downstream stalls 1,0,0,1
    toggle_mode = 1'b1;
    scan_vec[0] = 16'h1234;
    scan_vec[1] = 16'h5678;
    run_frame(3, 2);
    exp_q = '{16'hFFD8, 16'h1111, 16'h2222, 16'h3333, 16'h1234, 16'h5678, 16'hFFD9};
    check_stream("stall");
    chk("stall_hold", 32'(stall_bad), 32'd0);
    chk("stall_fw", 32'(fw_got), 32'd7);
    toggle_mode = 1'b0;
    tick();

    // Start re-pulsed during HDR and SCAN (with a different hdr_len)
    clear_obs();
    hdr_len = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(ST_HDR);
    hdr_len = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(ST_SCAN);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_scan(16'h1234, 1'b0);
    send_scan(16'h5678, 1'b1);
    wait_done();
    repeat (20) tick();
    exp_q = '{16'hFFD8, 16'h1111, 16'h2222, 16'h3333, 16'h1234, 16'h5678, 16'hFFD9};
    check_stream("repulse");
    chk("repulse_done_cnt", 32'(done_cnt), 32'd1);
    chk("repulse_busy", 32'(busy), 32'd0);
    chk("repulse_fw", 32'(fw_got), 32'd7);

    // Reset in the middle of SCAN, then a clean frame
    clear_obs();
    hdr_len = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(ST_SCAN);
    send_scan(16'h1234, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_st_rst", 32'(st_rst), 32'd1);
    chk("midrst_out_ena", 32'(out_ena), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_no_eoi", 32'(eoi_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_fw_clear", 32'(frame_words), 32'd0);
    scan_vec[0] = 16'hABCD;
    run_frame(1, 1);
    exp_q = '{16'hFFD8, 16'h1111, 16'hABCD, 16'hFFD9};
    check_stream("after_rst");
    chk("after_rst_fw", 32'(fw_got), 32'd4);

    // 10-word frame: wide counter reads 10, 3-bit counter saturates at 7
    scan_vec[0] = 16'h0101;
    scan_vec[1] = 16'h0202;
    scan_vec[2] = 16'h0303;
    scan_vec[3] = 16'h0404;
    scan_vec[4] = 16'h0505;
    run_frame(3, 5);
    exp_q = '{16'hFFD8, 16'h1111, 16'h2222, 16'h3333, 16'h0101,
              16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'hFFD9};
    check_stream("long");
    chk("long_fw", 32'(fw_got), 32'd10);
    chk("long_fw_sat", 32'(fw_got_s), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
